// File: rtl/ccm_pkg.sv
// ---------------------------------------------------------------------------
// ccm_pkg
// Shared constants and types for the CCM partial-sum writeback stage.
//   CCM_LANES      : pixels per MAC beat
//   CCM_PX_W       : signed pixel width
//   CCM_ACC_W      : accumulator width (pixel width + 10 bits of growth)
//   ccm_wb_state_t : writeback FSM state encoding
// ---------------------------------------------------------------------------
package ccm_pkg;

    localparam int CCM_LANES = 32;
    localparam int CCM_PX_W  = 16;
    localparam int CCM_ACC_W = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ccm_wb_state_t;

endpackage

// File: rtl/ccm_sat_relu.sv
// ---------------------------------------------------------------------------
// ccm_sat_relu
// Per-lane post-processing: saturates a signed ACC_W accumulator to a signed
// PX_W pixel, then optionally clamps negative results to zero.
// Optional feature macro: CCM_RELU_EN (defined -> negative results become 0).
// Ports:
//   acc_i : signed accumulator value (ACC_W bits)
//   px_o  : post-processed pixel (PX_W bits)
// ---------------------------------------------------------------------------
module ccm_sat_relu
    import ccm_pkg::*;
#(
    parameter int ACC_W = CCM_ACC_W,
    parameter int PX_W  = CCM_PX_W
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [PX_W-1:0]  px_o
);

    // The value fits in PX_W bits only when every bit from the pixel sign bit
    // upward agrees with the accumulator sign bit.
    logic [ACC_W-PX_W:0] top_w;
    logic                ovf_w;
    logic [PX_W-1:0]     sat_w;

    assign top_w = acc_i[ACC_W-1:PX_W-1];
    assign ovf_w = !((&top_w) || (~|top_w));

    always_comb begin
        sat_w = acc_i[PX_W-1:0];
        if (ovf_w) begin
            sat_w = acc_i[ACC_W-1] ? {1'b1, {(PX_W-1){1'b0}}}
                                   : {1'b0, {(PX_W-1){1'b1}}};
        end
    end

`ifdef CCM_RELU_EN
    assign px_o = sat_w[PX_W-1] ? '0 : sat_w;
`else
    assign px_o = sat_w;
`endif

endmodule

// File: rtl/ccm_psum_writeback.sv
// ---------------------------------------------------------------------------
// ccm_psum_writeback
// Accumulates CFG_NUM_FMAP MAC beats (LANES x PX_W signed partial sums) per
// output tile, saturates (and optionally ReLUs) each lane, then writes the
// LANES results to pixel memory one word per grant.
// Optional feature macro: CCM_RELU_EN (handled inside ccm_sat_relu).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   op_start / op_done  : start pulse (IDLE only) / completion pulse
//   status              : busy, high outside IDLE
//   MAC_IN, PRE_TAKE_*  : MAC beat input with valid/ready handshake
//   pxMem_WR_*          : pixel memory write port (request/grant)
//   CFG_*               : operation config, latched on accepted op_start
//   dbg_state_o         : current FSM state, for observation only
//
// Handshakes: a MAC beat transfers on a rising edge where PRE_TAKE_VLD and
// PRE_TAKE_RDY are both high; a write transfers on a rising edge where
// pxMem_WR_REQ and pxMem_WR_GRANT are both high. While REQ is high and GRANT
// is low, address and data hold their values.
// ---------------------------------------------------------------------------
module ccm_psum_writeback
    import ccm_pkg::*;
#(
    parameter int LANES = CCM_LANES,
    parameter int PX_W  = CCM_PX_W,
    parameter int ACC_W = CCM_ACC_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_start,
    output logic                  status,
    output logic                  op_done,
    input  logic [LANES*PX_W-1:0] MAC_IN,
    input  logic                  PRE_TAKE_VLD,
    output logic                  PRE_TAKE_RDY,
    output logic                  pxMem_WR_REQ,
    input  logic                  pxMem_WR_GRANT,
    output logic [19:0]           pxMem_WR_Addr,
    output logic [PX_W-1:0]       pxMem_WR_Data,
    input  logic [9:0]            CFG_NUM_FMAP,
    input  logic [15:0]           CFG_NUM_TILES,
    input  logic [19:0]           CFG_OUT_BASE_ADDR,
    output ccm_wb_state_t         dbg_state_o
);

    localparam int IDX_W = $clog2(LANES);

    ccm_wb_state_t    state_q, state_d;
    logic [9:0]       nfmap_q, nfmap_d;
    logic [15:0]      ntiles_q, ntiles_d;
    logic [9:0]       fmap_q, fmap_d;
    logic [15:0]      tile_q, tile_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [19:0]      addr_q, addr_d;
    logic             status_q, status_d;
    logic             done_q, done_d;
    logic             rdy_q, rdy_d;
    logic             req_q, req_d;
    logic [ACC_W-1:0] acc_q [LANES];
    logic [ACC_W-1:0] acc_d [LANES];
    logic [PX_W-1:0]  sat_w [LANES];

    logic             accept_w;
    logic [9:0]       fmap_last_w;

    assign accept_w    = PRE_TAKE_VLD & rdy_q;
    // A configured count of zero behaves as a single beat per tile.
    assign fmap_last_w = (nfmap_q == 10'd0) ? 10'd0 : nfmap_q - 10'd1;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ccm_sat_relu #(.ACC_W(ACC_W), .PX_W(PX_W)) u_sat (
            .acc_i (acc_q[g]),
            .px_o  (sat_w[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        nfmap_d  = nfmap_q;
        ntiles_d = ntiles_q;
        fmap_d   = fmap_q;
        tile_d   = tile_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        acc_d    = acc_q;

        case (state_q)
            IDLE: begin
                if (op_start) begin
                    nfmap_d  = CFG_NUM_FMAP;
                    ntiles_d = CFG_NUM_TILES;
                    fmap_d   = '0;
                    tile_d   = '0;
                    idx_d    = '0;
                    addr_d   = CFG_OUT_BASE_ADDR;
                    for (int i = 0; i < LANES; i++) acc_d[i] = '0;
                    state_d  = (CFG_NUM_TILES == 16'd0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept_w) begin
                    for (int i = 0; i < LANES; i++) begin
                        // The first beat of a tile overwrites, so no clear
                        // cycle is needed between tiles.
                        if (fmap_q == 10'd0)
                            acc_d[i] = {{(ACC_W-PX_W){MAC_IN[i*PX_W+PX_W-1]}}, MAC_IN[i*PX_W +: PX_W]};
                        else
                            acc_d[i] = acc_q[i] + {{(ACC_W-PX_W){MAC_IN[i*PX_W+PX_W-1]}}, MAC_IN[i*PX_W +: PX_W]};
                    end
                    fmap_d = fmap_q + 10'd1;
                    if (fmap_q == fmap_last_w) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pxMem_WR_GRANT) begin
                    addr_d = addr_q + 20'd1;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == IDX_W'(LANES-1)) begin
                        if (tile_q == ntiles_q - 16'd1) begin
                            state_d = DONE;
                        end else begin
                            tile_d  = tile_q + 16'd1;
                            idx_d   = '0;
                            fmap_d  = '0;
                            state_d = ACCUM;
                        end
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of the next-state decode so they line
        // up with the state they describe.
        status_d = (state_d != IDLE);
        done_d   = (state_d == DONE);
        rdy_d    = (state_d == ACCUM);
        req_d    = (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            nfmap_q  <= '0;
            ntiles_q <= '0;
            fmap_q   <= '0;
            tile_q   <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            status_q <= 1'b0;
            done_q   <= 1'b0;
            rdy_q    <= 1'b0;
            req_q    <= 1'b0;
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            nfmap_q  <= nfmap_d;
            ntiles_q <= ntiles_d;
            fmap_q   <= fmap_d;
            tile_q   <= tile_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            status_q <= status_d;
            done_q   <= done_d;
            rdy_q    <= rdy_d;
            req_q    <= req_d;
            for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
        end
    end

    assign status        = status_q;
    assign op_done       = done_q;
    assign PRE_TAKE_RDY  = rdy_q;
    assign pxMem_WR_REQ  = req_q;
    assign pxMem_WR_Addr = addr_q;
    assign pxMem_WR_Data = sat_w[idx_q];
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ccm_psum_writeback.sv
module tb_ccm_psum_writeback;
    import ccm_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          op_start = 1'b0;
    logic          status, op_done, rdy, req;
    logic [511:0]  mac_in = '0;
    logic          vld = 1'b0;
    logic          grant = 1'b0;
    logic [19:0]   addr;
    logic [15:0]   data;
    logic [9:0]    cfg_fmap = '0;
    logic [15:0]   cfg_tiles = '0;
    logic [19:0]   cfg_base = '0;
    ccm_wb_state_t dbg_state;

    ccm_psum_writeback dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .op_start          (op_start),
        .status            (status),
        .op_done           (op_done),
        .MAC_IN            (mac_in),
        .PRE_TAKE_VLD      (vld),
        .PRE_TAKE_RDY      (rdy),
        .pxMem_WR_REQ      (req),
        .pxMem_WR_GRANT    (grant),
        .pxMem_WR_Addr     (addr),
        .pxMem_WR_Data     (data),
        .CFG_NUM_FMAP      (cfg_fmap),
        .CFG_NUM_TILES     (cfg_tiles),
        .CFG_OUT_BASE_ADDR (cfg_base),
        .dbg_state_o       (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass = 0;
    logic [35:0] exp_q[$];
    int grant_mode = 0;
    int gcnt = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int req_cnt = 0;
    int done_cnt = 0;
    int last_grant_cyc = 0;
    int done_cyc = 0;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [15:0] pp(input int v);
        int s;
        s = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
`ifdef CCM_RELU_EN
        if (s < 0) s = 0;
`endif
        return 16'(s);
    endfunction

    // grant pattern: 0 = always, 1 = one on / two off, 2 = never
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (grant_mode)
                0: grant = 1'b1;
                1: begin grant = (gcnt % 3 == 0); gcnt++; end
                default: grant = 1'b0;
            endcase
        end
    end

    // write-port monitor, sampled away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (op_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (req) begin
                req_cnt++;
                check("rdy_low_in_drain", rdy, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_req", req, 1'b0);
                end else if (grant) begin
                    check("write", {addr, data}, exp_q.pop_front());
                    wr_cnt++;
                    last_grant_cyc = cyc;
                end else begin
                    check("hold_stable", {addr, data}, exp_q[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [9:0] nf, input logic [15:0] nt, input logic [19:0] base);
        cfg_fmap  = nf;
        cfg_tiles = nt;
        cfg_base  = base;
        op_start  = 1'b1;
        @(posedge clk);
        #1;
        op_start  = 1'b0;
        // scramble config to show it was latched
        cfg_fmap  = 10'($urandom_range(0, 1023));
        cfg_tiles = 16'($urandom_range(0, 65535));
        cfg_base  = 20'($urandom_range(0, 1048575));
    endtask

    task automatic send_beat(input logic [511:0] d);
        int n;
        n = 0;
        vld = 1'b1;
        mac_in = d;
        forever begin
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 500) begin
                check("beat_accept_timeout", 1'b0, 1'b1);
                vld = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    task automatic finish_op(input string tag, input int wr0, input int d0, input int nwr, output int ncyc);
        ncyc = 0;
        while (done_cnt == d0 && ncyc < 3000) begin
            @(posedge clk);
            ncyc++;
        end
        #1;
        check({tag, "_done_seen"}, done_cnt > d0, 1'b1);
        check({tag, "_writes"}, 36'(wr_cnt - wr0), 36'(nwr));
        if (nwr > 0) check({tag, "_done_lat"}, 36'(done_cyc - last_grant_cyc), 36'd1);
        check({tag, "_queue_empty"}, 36'(exp_q.size()), 36'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_one_done"}, 36'(done_cnt - d0), 36'd1);
        check({tag, "_idle"}, status, 1'b0);
    endtask

    // ---------------- directed tests ----------------
    int wr0, d0, r0, nc, v;
    int sums[32];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_status", status, 1'b0);
        check("rst_done", op_done, 1'b0);
        check("rst_rdy", rdy, 1'b0);
        check("rst_req", req, 1'b0);
        check("rst_addr", addr, 20'h0);
        check("rst_data", data, 16'h0);
        check("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single tile, lane i = i
        grant_mode = 0;
        for (int i = 0; i < 32; i++) exp_q.push_back({20'h00100 + 20'(i), 16'(i)});
        wr0 = wr_cnt; d0 = done_cnt;
        start_op(10'd1, 16'd1, 20'h00100);
        @(negedge clk);
        check("t1_rdy_after_start", rdy, 1'b1);
        check("t1_busy", status, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) mac_in[i*16 +: 16] = 16'(i);
        send_beat(mac_in);
        @(negedge clk);
        check("t1_req_after_beat", req, 1'b1);
        finish_op("t1", wr0, d0, 32, nc);

        // accumulation of three beats of 0x1000
        for (int i = 0; i < 32; i++) exp_q.push_back({20'h00200 + 20'(i), 16'h3000});
        wr0 = wr_cnt; d0 = done_cnt;
        start_op(10'd3, 16'd1, 20'h00200);
        for (int i = 0; i < 32; i++) mac_in[i*16 +: 16] = 16'h1000;
        repeat (3) send_beat(mac_in);
        finish_op("t2", wr0, d0, 32, nc);

        // saturation: even lanes 0x7000, odd lanes 0x8000, four beats
        for (int i = 0; i < 32; i++)
            exp_q.push_back({20'h00300 + 20'(i), (i % 2 == 0) ? pp(4 * 28672) : pp(4 * -32768)});
        wr0 = wr_cnt; d0 = done_cnt;
        start_op(10'd4, 16'd1, 20'h00300);
        for (int i = 0; i < 32; i++) mac_in[i*16 +: 16] = (i % 2 == 0) ? 16'h7000 : 16'h8000;
        repeat (4) send_beat(mac_in);
        finish_op("t3", wr0, d0, 32, nc);

        // backpressure: sparse grant, valid gap mid-tile, signed values
        grant_mode = 1;
        for (int i = 0; i < 32; i++) exp_q.push_back({20'h00400 + 20'(i), pp(600 * (i - 16))});
        wr0 = wr_cnt; d0 = done_cnt;
        start_op(10'd3, 16'd1, 20'h00400);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 32; i++) begin
                v = (i - 16) * 100 * (b + 1);
                mac_in[i*16 +: 16] = 16'(v);
            end
            send_beat(mac_in);
            if (b == 0) repeat (5) @(posedge clk);
            #1;
        end
        finish_op("t4", wr0, d0, 32, nc);

        // two tiles with address wrap
        grant_mode = 0;
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < 32; i++)
                exp_q.push_back({20'hFFFF0 + 20'(t * 32 + i), pp(2 * i + 200 * t + 1)});
        wr0 = wr_cnt; d0 = done_cnt;
        start_op(10'd2, 16'd2, 20'hFFFF0);
        for (int t = 0; t < 2; t++) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 32; i++) mac_in[i*16 +: 16] = 16'(i + 100 * t + b);
                send_beat(mac_in);
            end
        end
        finish_op("t5", wr0, d0, 64, nc);

        // zero tiles: straight to done with no request
        r0 = req_cnt; wr0 = wr_cnt; d0 = done_cnt;
        start_op(10'd5, 16'd0, 20'h00700);
        finish_op("t6", wr0, d0, 0, nc);
        check("t6_done_latency_ok", nc <= 2, 1'b1);
        check("t6_no_req", 36'(req_cnt - r0), 36'd0);

        // reset while draining, then a clean rerun
        grant_mode = 2;
        for (int i = 0; i < 32; i++) exp_q.push_back({20'h00800 + 20'(i), 16'(i + 7)});
        start_op(10'd1, 16'd1, 20'h00800);
        for (int i = 0; i < 32; i++) mac_in[i*16 +: 16] = 16'(i + 7);
        send_beat(mac_in);
        repeat (3) @(negedge clk);
        check("t7_req_before_rst", req, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("t7_req_in_rst", req, 1'b0);
        check("t7_busy_in_rst", status, 1'b0);
        check("t7_state_in_rst", dbg_state, IDLE);
        exp_q.delete();
        grant_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) exp_q.push_back({20'h00900 + 20'(i), pp(100 - 7 * i)});
        wr0 = wr_cnt; d0 = done_cnt;
        start_op(10'd1, 16'd1, 20'h00900);
        for (int i = 0; i < 32; i++) begin
            v = 100 - 7 * i;
            mac_in[i*16 +: 16] = 16'(v);
        end
        send_beat(mac_in);
        finish_op("t7", wr0, d0, 32, nc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
